// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush scheduler.
package pipe_ctrl_pkg;

    // Scheduler states.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MD_BUSY  = 2'd2
    } state_t;

    // ResultSrc encoding that marks a load in Execute.
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    // x0 never creates a dependency.
    localparam logic [4:0] ZERO_REG = 5'd0;

    // Width of the MUL/DIV busy counter; enough for MD_LATENCY up to 32.
    localparam int MD_CNT_W = 5;

endpackage : pipe_ctrl_pkg

// File: rtl/pipeline_ctrl_hazard_terms.sv
// Combinational hazard detection: load-use dependency and data-memory wait.
module hazard_terms
    import pipe_ctrl_pkg::*;
(
    input  logic [1:0] ResultSrcE,
    input  logic [4:0] RD_E,
    input  logic [4:0] RS1_D,
    input  logic [4:0] RS2_D,
    input  logic       MemReqM,
    input  logic       MemReadyM,
    output logic       lw_stall,
    output logic       mem_wait
);

    // A load in E whose (non-x0) destination is read by the instruction in D.
    always_comb begin
        lw_stall = (ResultSrcE == RESULT_SRC_LOAD) && (RD_E != ZERO_REG) &&
                   ((RS1_D == RD_E) || (RS2_D == RD_E));
        mem_wait = MemReqM && !MemReadyM;
    end

endmodule : hazard_terms

// File: rtl/pipeline_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline: merges load-use,
// branch redirect, data-memory wait and multi-cycle MUL/DIV occupancy into
// per-stage stall and flush controls.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       RD_E,
    input  logic [4:0]       RS1_D,
    input  logic [4:0]       RS2_D,
    input  logic             MdOpE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic             MdStartE,
    output logic             MdDoneE,
    output logic [CNT_W-1:0] StallCount
);

    // Busy cycles between the start and done cycles of a MUL/DIV op.
    localparam logic [MD_CNT_W-1:0] MD_BUSY_LOAD = MD_CNT_W'(MD_LATENCY - 2);

    state_t              state, state_next;
    logic [MD_CNT_W-1:0] md_cnt, md_cnt_next;
    logic                lw_stall;
    logic                mem_wait;

    hazard_terms u_hazard_terms (
        .ResultSrcE (ResultSrcE),
        .RD_E       (RD_E),
        .RS1_D      (RS1_D),
        .RS2_D      (RS2_D),
        .MemReqM    (MemReqM),
        .MemReadyM  (MemReadyM),
        .lw_stall   (lw_stall),
        .mem_wait   (mem_wait)
    );

    // State and MUL/DIV counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_next;
            md_cnt <= md_cnt_next;
        end
    end

    // Next-state and stall/flush decode; everything is held low during reset.
    always_comb begin
        state_next  = state;
        md_cnt_next = md_cnt;
        StallF      = 1'b0;
        StallD      = 1'b0;
        StallE      = 1'b0;
        StallM      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        FlushM      = 1'b0;
        FlushW      = 1'b0;
        MdStartE    = 1'b0;
        MdDoneE     = 1'b0;

        if (!rst) begin
            unique case (state)
                RUN: begin
                    if (mem_wait) begin
                        // M cannot retire: freeze F..M, bubble into W.
                        StallF     = 1'b1;
                        StallD     = 1'b1;
                        StallE     = 1'b1;
                        StallM     = 1'b1;
                        FlushW     = 1'b1;
                        state_next = MEM_WAIT;
                    end else if (MdOpE) begin
                        // Hold F..E around the MUL/DIV op, bubble into M.
                        StallF      = 1'b1;
                        StallD      = 1'b1;
                        StallE      = 1'b1;
                        FlushM      = 1'b1;
                        MdStartE    = 1'b1;
                        md_cnt_next = MD_BUSY_LOAD;
                        state_next  = MD_BUSY;
                    end else begin
                        // A taken branch squashes D anyway, so it overrides the load-use stall.
                        FlushD = PCSrcE;
                        FlushE = PCSrcE || lw_stall;
                        StallF = lw_stall && !PCSrcE;
                        StallD = lw_stall && !PCSrcE;
                    end
                end

                MEM_WAIT: begin
                    if (!MemReadyM) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        StallE = 1'b1;
                        StallM = 1'b1;
                        FlushW = 1'b1;
                    end else begin
                        // Ready cycle: everything advances; hazards re-checked in RUN.
                        state_next = RUN;
                    end
                end

                MD_BUSY: begin
                    if (md_cnt == '0) begin
                        // Result valid; leaving to RUN keeps the next E op from
                        // looking like a fresh start this cycle.
                        MdDoneE    = 1'b1;
                        state_next = RUN;
                    end else begin
                        StallF      = 1'b1;
                        StallD      = 1'b1;
                        StallE      = 1'b1;
                        FlushM      = 1'b1;
                        md_cnt_next = md_cnt - 1'b1;
                    end
                end

                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    // Performance counter of fetch-stall cycles; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            StallCount <= '0;
        end else if (StallF) begin
            StallCount <= StallCount + CNT_W'(1);
        end
    end

endmodule : pipeline_ctrl

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: per-cycle expected control vectors
// are queued as stimulus is driven and compared when the outputs settle.
module tb_pipeline_ctrl;

    localparam int CNT_W = 32;

    // Expected control vector layout:
    // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW,MdStartE,MdDoneE}
    localparam logic [9:0] E_IDLE = 10'b00_0000_0000;
    localparam logic [9:0] E_LU   = 10'b11_0000_0000 | 10'b00_0001_0000;
    localparam logic [9:0] E_BR   = 10'b00_0011_0000;
    localparam logic [9:0] E_MW   = 10'b11_1100_0100;
    localparam logic [9:0] E_MDS  = 10'b11_1000_1010;
    localparam logic [9:0] E_MDB  = 10'b11_1000_1000;
    localparam logic [9:0] E_MDD  = 10'b00_0000_0001;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       ResultSrcE;
    logic             PCSrcE;
    logic [4:0]       RD_E, RS1_D, RS2_D;
    logic             MdOpE, MemReqM, MemReadyM;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushM, FlushW;
    logic             MdStartE, MdDoneE;
    logic [CNT_W-1:0] StallCount;

    int checks = 0;
    int errors = 0;
    int exp_sc = 0;

    logic [9:0] exp_q[$];
    string      tag_q[$];

    pipeline_ctrl #(.MD_LATENCY(4), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ResultSrcE (ResultSrcE),
        .PCSrcE     (PCSrcE),
        .RD_E       (RD_E),
        .RS1_D      (RS1_D),
        .RS2_D      (RS2_D),
        .MdOpE      (MdOpE),
        .MemReqM    (MemReqM),
        .MemReadyM  (MemReadyM),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .FlushM     (FlushM),
        .FlushW     (FlushW),
        .MdStartE   (MdStartE),
        .MdDoneE    (MdDoneE),
        .StallCount (StallCount)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: compare settled outputs against the oldest queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [9:0] e;
            string      t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_eq(t, {StallF, StallD, StallE, StallM, FlushD, FlushE,
                         FlushM, FlushW, MdStartE, MdDoneE}, {54'd0, e});
        end
    end

    // Drive one cycle of stimulus and queue the outputs expected during it.
    task automatic step(input string tag, input logic r, input logic [1:0] rs,
                        input logic pcs, input logic [4:0] rd, input logic [4:0] s1,
                        input logic [4:0] s2, input logic md, input logic req,
                        input logic rdy, input logic [9:0] exp);
        rst        = r;
        ResultSrcE = rs;
        PCSrcE     = pcs;
        RD_E       = rd;
        RS1_D      = s1;
        RS2_D      = s2;
        MdOpE      = md;
        MemReqM    = req;
        MemReadyM  = rdy;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        if (r) exp_sc = 0;
        else if (exp[9]) exp_sc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_IDLE);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; ResultSrcE = '0; PCSrcE = 1'b0; RD_E = '0; RS1_D = '0; RS2_D = '0;
        MdOpE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
        @(posedge clk);
        #1;

        // Reset forces outputs low even with hazard inputs active.
        step("rst_md",  1'b1, 2'b01, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, E_IDLE);
        step("rst_mem", 1'b1, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, E_IDLE);
        check_eq("sc_reset", StallCount, 64'(exp_sc));
        idle("idle0");

        // Load-use on rs1 and rs2 for one cycle each.
        step("lu_rs1", 1'b0, 2'b01, 1'b0, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0, E_LU);
        idle("lu_rel");
        check_eq("sc_lu", StallCount, 64'(exp_sc));
        step("lu_rs2", 1'b0, 2'b01, 1'b0, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, E_LU);
        step("nonload", 1'b0, 2'b00, 1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, E_IDLE);

        // Load into x0 never stalls; branch overrides load-use.
        step("ld_x0",  1'b0, 2'b01, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_IDLE);
        step("br_lu",  1'b0, 2'b01, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, E_BR);
        step("br",     1'b0, 2'b00, 1'b1, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, E_BR);
        check_eq("sc_br", StallCount, 64'(exp_sc));

        // Memory wait: 3 wait cycles (branch/load-use ignored), then ready.
        step("mw1", 1'b0, 2'b01, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, E_MW);
        step("mw2", 1'b0, 2'b00, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, E_MW);
        step("mw3", 1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, E_MW);
        step("mw_rdy", 1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, E_IDLE);
        step("mw_run", 1'b0, 2'b01, 1'b0, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, E_LU);
        check_eq("sc_mw", StallCount, 64'(exp_sc));

        // MUL/DIV held high: start, two busy, done, no restart in done cycle.
        step("md_start", 1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, E_MDS);
        step("md_busy1", 1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, E_MDB);
        step("md_busy2", 1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, E_MDB);
        step("md_done",  1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, E_MDD);
        idle("md_after");
        check_eq("sc_md", StallCount, 64'(exp_sc));

        // Memory wait coinciding with MUL/DIV: memory first, start after ready.
        step("sim_mw1", 1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, E_MW);
        step("sim_mw2", 1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, E_MW);
        step("sim_rdy", 1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, E_IDLE);
        step("sim_mds", 1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, E_MDS);
        step("sim_mdb1", 1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, E_MDB);
        step("sim_mdb2", 1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, E_MDB);
        step("sim_mdd", 1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_MDD);
        check_eq("sc_sim", StallCount, 64'(exp_sc));

        // Reset on the second busy cycle: no done pulse, back in RUN.
        step("rb_start", 1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, E_MDS);
        step("rb_busy1", 1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, E_MDB);
        step("rb_rst",   1'b1, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, E_IDLE);
        check_eq("sc_rst_md", StallCount, 64'(exp_sc));
        idle("rb_nodone");
        step("rb_run_lu", 1'b0, 2'b01, 1'b0, 5'd6, 5'd0, 5'd6, 1'b0, 1'b0, 1'b0, E_LU);
        idle("rb_idle");
        check_eq("sc_final", StallCount, 64'(exp_sc));

        check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pipeline_ctrl

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage RV32I pipeline (F/D/E/M/W).
- Merges three hazard sources into one set of per-stage stall and flush controls:
  - load-use hazards
  - taken branch/jump redirects
  - multi-cycle events: data-memory wait on a req/ready handshake, and an iterative MUL/DIV unit in Execute.
- Owns a small FSM and a latency counter; sits beside the pipeline registers and drives their enable/clear inputs.

Parameters:
- MD_LATENCY, 4, total cycles a MUL/DIV op occupies Execute (legal range 2..32).
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- ResultSrcE  in  2  result select of the instruction in E; 2'b01 means load.
- PCSrcE  in  1  branch/jump taken, resolved in E.
- RD_E  in  5  destination register of the instruction in E.
- RS1_D  in  5  source register 1 of the instruction in D.
- RS2_D  in  5  source register 2 of the instruction in D.
- MdOpE  in  1  instruction in E is MUL/DIV.
- MemReqM  in  1  instruction in M accesses data memory.
- MemReadyM  in  1  data memory completes the access this cycle.
- StallF  out  1  hold PC.
- StallD  out  1  hold IF/ID register.
- StallE  out  1  hold ID/EX register.
- StallM  out  1  hold EX/MEM register.
- FlushD  out  1  clear IF/ID register.
- FlushE  out  1  clear ID/EX register.
- FlushM  out  1  clear EX/MEM register (bubble).
- FlushW  out  1  clear MEM/WB register (bubble).
- MdStartE  out  1  one-cycle start pulse to the MUL/DIV unit.
- MdDoneE  out  1  last cycle of the MUL/DIV op; its result is valid.
- StallCount  out  CNT_W  cycles in which StallF=1; wraps modulo 2^CNT_W.

Behaviour:
- Clock and reset:
  - Single clock.
  - rst is synchronous and active-high.
  - On rst: state=RUN, md counter=0, StallCount=0.
  - While rst=1, all combinational outputs are forced to 0.
  - Reset mid-operation (MEM_WAIT or MD_BUSY) goes to RUN next edge and MdDoneE is not pulsed.
- Hazard terms:
  - Outputs are combinational from state, counter and inputs.
  - lwStall = (ResultSrcE==2'b01) & (RD_E!=0) & ((RS1_D==RD_E) | (RS2_D==RD_E)).
  - memWait = MemReqM & ~MemReadyM.
- State RUN, evaluated in priority order:
  1. memWait:
     - Outputs: StallF=StallD=StallE=StallM=1, FlushW=1; all other outputs 0.
     - PCSrcE and lwStall are ignored because E does not advance.
     - Next state MEM_WAIT.
  2. else MdOpE:
     - Outputs: StallF=StallD=StallE=1, FlushM=1, MdStartE=1.
     - Counter loads MD_LATENCY-2.
     - Next state MD_BUSY.
  3. else (stay in RUN):
     - FlushD = PCSrcE.
     - FlushE = PCSrcE | lwStall.
     - StallF = StallD = lwStall & ~PCSrcE (branch wins; D is flushed anyway).
- State MEM_WAIT:
  - While MemReadyM=0: same outputs as RUN case 1.
  - On the cycle MemReadyM=1: all outputs 0 and the pipeline advances; next state RUN.
  - Load-use and branch hazards in D/E are re-evaluated in RUN on the following cycle.
- State MD_BUSY:
  - Outputs: StallF=StallD=StallE=1, FlushM=1.
  - Counter decrements each cycle.
  - When counter==0:
    - MdDoneE=1 and all stalls/flushes are 0, so E advances.
    - Next state RUN. The new E instruction is therefore never mistaken for a second start.
  - MemReqM is guaranteed 0 here because M holds bubbles.
- Timing:
  - Total E occupancy of a MUL/DIV op = MD_LATENCY cycles: start cycle + MD_LATENCY-2 busy cycles + done cycle.
  - With MD_LATENCY=2 the done cycle immediately follows the start cycle.
- Simultaneous events:
  - Memory wait together with MdOpE: memory is served first. MdOpE is still asserted on return to RUN, so the MUL/DIV op starts then.
  - Branch together with lwStall: the flush wins.
- StallCount increments on every non-reset cycle where StallF=1.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state enum {RUN, MEM_WAIT, MD_BUSY}
  - RESULT_SRC_LOAD = 2'b01
  - ZERO_REG = 5'd0
- One natural combinational sub-module, hazard_terms, computes lwStall and memWait.
- The FSM, counter and output decode stay in pipeline_ctrl.

Test Plan:
- Load-use: ResultSrcE=01, RD_E=5, RS1_D=5, rest idle -> StallF=StallD=FlushE=1 for exactly 1 cycle; StallCount increments by 1.
- Load to x0 plus branch: RD_E=0, RS1_D=0, ResultSrcE=01 -> no stall. Then PCSrcE=1 together with a matching lwStall -> FlushD=FlushE=1, StallF=0.
- Memory wait: MemReqM=1 with MemReadyM low for 3 cycles then high -> StallF/D/E/M and FlushW high for 3 cycles, all outputs 0 on the ready cycle, state returns to RUN.
- MUL/DIV with MD_LATENCY=4: MdOpE=1 held -> MdStartE pulses once; stalls high for 3 cycles; MdDoneE=1 on cycle 4 with stalls 0; no second MdStartE.
- Simultaneous: MemReqM=1, MemReadyM=0 for 2 cycles with MdOpE=1 -> MEM_WAIT first; MdStartE asserts the cycle after the ready cycle.
- Reset in MD_BUSY: rst asserted on the 2nd busy cycle -> all outputs 0, MdDoneE never pulses, StallCount=0, RUN after rst falls.
